// File: rtl/rfft_mem_pkg.sv
// rtl/rfft_mem_pkg.sv - shared constants and helpers for the FFT sample/twiddle store
package rfft_mem_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MODE_SHARED   = 0;
  localparam int MODE_PINGPONG = 1;

  // Smallest r with (1 << r) >= value; used to derive address widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_bank.sv
// rtl/bram_bank.sv - one DEPTH x WIDTH true dual-port array with per-port read-during-write policy
module bram_bank
  import rfft_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int AW       = clog2(DEPTH),
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic             clk,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] di_a,
  output logic [WIDTH-1:0] rd_a,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] di_b,
  output logic [WIDTH-1:0] rd_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_a;
  logic wr_b;
  logic same_addr;

  assign wr_a      = en_a & we_a;
  assign same_addr = (addr_a == addr_b);
  // Port A wins a double write to the same word, so port B backs off.
  assign wr_b      = en_b & we_b & ~(wr_a & same_addr);

  // Array update; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_a) mem[addr_a] <= di_a;
    if (wr_b) mem[addr_b] <= di_b;
  end

  // Read words: the other port always sees the pre-edge contents; own write bypasses only in write-first.
  always_comb begin
    rd_a = mem[addr_a];
    rd_b = mem[addr_b];
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (wr_a) rd_a = di_a;
      if (en_b && we_b) rd_b = di_b;
    end
  end

endmodule

// File: rtl/bram_dual_pp.sv
// rtl/bram_dual_pp.sv - dual-port block RAM with optional ping-pong banking, output register and collision flag
module bram_dual_pp
  import rfft_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int AW       = clog2(DEPTH),
  parameter int PINGPONG = MODE_SHARED,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OREG     = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Swap,
  input  logic             We_A,
  input  logic [AW-1:0]    Addr_A,
  input  logic [WIDTH-1:0] DI_A,
  output logic [WIDTH-1:0] DO_A,
  output logic             Vld_A,
  input  logic             We_B,
  input  logic [AW-1:0]    Addr_B,
  input  logic [WIDTH-1:0] DI_B,
  output logic [WIDTH-1:0] DO_B,
  output logic             Vld_B,
  output logic             Bank,
  output logic             Collision
);

  // Writes are suppressed on any edge where reset is held.
  logic acc_en;
  assign acc_en = En & ~Rst;

  logic             bank_q, bank_d;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] do1_a_q, do1_a_d, do1_b_q, do1_b_d;
  logic [WIDTH-1:0] do2_a_q, do2_a_d, do2_b_q, do2_b_d;
  logic             vld1_q, vld1_d, vld2_q, vld2_d;
  logic             col_q, col_d;

  generate
    if (PINGPONG == MODE_PINGPONG) begin : g_pp
      logic [WIDTH-1:0] rda [2];
      logic [WIDTH-1:0] rdb [2];
      for (genvar k = 0; k < 2; k++) begin : g_bank
        logic sel_a;
        // Bank k belongs to port A when Bank==k, otherwise to port B.
        assign sel_a = (bank_q == 1'(k));
        bram_bank #(
          .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RDW_MODE(RDW_MODE)
        ) u_bank (
          .clk(Clk),
          .en_a(acc_en & sel_a), .we_a(We_A), .addr_a(Addr_A), .di_a(DI_A), .rd_a(rda[k]),
          .en_b(acc_en & ~sel_a), .we_b(We_B), .addr_b(Addr_B), .di_b(DI_B), .rd_b(rdb[k])
        );
      end
      assign rd_a = rda[bank_q];
      assign rd_b = rdb[~bank_q];
    end else begin : g_shared
      bram_bank #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RDW_MODE(RDW_MODE)
      ) u_bank (
        .clk(Clk),
        .en_a(acc_en), .we_a(We_A), .addr_a(Addr_A), .di_a(DI_A), .rd_a(rd_a),
        .en_b(acc_en), .we_b(We_B), .addr_b(Addr_B), .di_b(DI_B), .rd_b(rd_b)
      );
    end
  endgenerate

  // Next state: bank toggle, read capture, collision detect and the free-running output stage.
  always_comb begin
    bank_d  = bank_q;
    do1_a_d = do1_a_q;
    do1_b_d = do1_b_q;
    if ((PINGPONG == MODE_PINGPONG) && En && Swap) bank_d = ~bank_q;
    if (En) begin
      do1_a_d = rd_a;
      do1_b_d = rd_b;
    end
    vld1_d  = En;
    // Separate banks can never alias, so only the shared array can collide.
    col_d   = En && (PINGPONG == MODE_SHARED) && (Addr_A == Addr_B) && (We_A || We_B);
    do2_a_d = do1_a_q;
    do2_b_d = do1_b_q;
    vld2_d  = vld1_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bank_q  <= 1'b0;
      do1_a_q <= '0;
      do1_b_q <= '0;
      do2_a_q <= '0;
      do2_b_q <= '0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      col_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      do1_a_q <= do1_a_d;
      do1_b_q <= do1_b_d;
      do2_a_q <= do2_a_d;
      do2_b_q <= do2_b_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      col_q   <= col_d;
    end
  end

  assign DO_A      = (OREG != 0) ? do2_a_q : do1_a_q;
  assign DO_B      = (OREG != 0) ? do2_b_q : do1_b_q;
  assign Vld_A     = (OREG != 0) ? vld2_q : vld1_q;
  assign Vld_B     = (OREG != 0) ? vld2_q : vld1_q;
  assign Bank      = bank_q;
  assign Collision = col_q;

endmodule

// File: doc/bram_dual_pp.md
Name: bram_dual_pp

Overview:
- Parametrised true dual-port block RAM; next generation of the FFT sample/twiddle store.
- Generalised in width and depth; selectable read-during-write policy; optional output register.
- Optional ping-pong (double-buffer) mode: port A fills one bank while port B drains the other, with a swap handshake between FFT frames.
- Detects and flags same-address port collisions; sits between the input sample loader and the butterfly datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 64, words per bank; must be a power of two, at least 2.
- AW, clog2(DEPTH), address width; derived, do not override.
- PINGPONG, 0. 0 = single shared array; 1 = two banks, port A on bank Bank, port B on bank ~Bank.
- RDW_MODE, 0. Same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- OREG, 0. 1 adds an output register stage: read latency becomes 2.

Ports:
- Clk  in  1  Clock; all state changes on the rising edge.
- Rst  in  1  Asynchronous, active-high reset.
- En  in  1  Global access enable for both ports.
- Swap  in  1  Bank swap request; sampled only when En=1 and PINGPONG=1.
- We_A  in  1  Port A write enable.
- Addr_A  in  AW  Port A address.
- DI_A  in  WIDTH  Port A write data.
- DO_A  out  WIDTH  Port A read data.
- Vld_A  out  1  DO_A carries data from an access this cycle.
- We_B  in  1  Port B write enable.
- Addr_B  in  AW  Port B address.
- DI_B  in  WIDTH  Port B write data.
- DO_B  out  WIDTH  Port B read data.
- Vld_B  out  1  DO_B carries data from an access this cycle.
- Bank  out  1  Bank currently owned by port A; always 0 when PINGPONG=0.
- Collision  out  1  One-cycle pulse flagging a same-address conflict.

Behaviour:
- Reset:
  - DO_A, DO_B, Vld_A, Vld_B, Bank and Collision go to 0, plus any OREG stage contents.
  - Memory contents are not reset.
  - Rst mid-operation discards in-flight reads; no write completes on a cycle where Rst is high.
- Access cycle:
  - An access happens on the edge where En=1. That port writes if its We is set, and always reads.
  - Read latency is 1 cycle (OREG=0) or 2 cycles (OREG=1).
  - Vld_x is En delayed by the same latency.
- En=0:
  - No write and no read.
  - DO_A and DO_B hold their values; Vld goes low after the pipeline drains.
  - The OREG stage still advances each cycle.
- Same-port read-during-write: DO_x returns the old word (RDW_MODE=0) or DI_x (RDW_MODE=1).
- Cross-port same address:
  - The reading port always gets the old word.
  - If both ports write, port A wins.
  - In either case Collision pulses 1 cycle after the access edge.
- Collision condition: En=1, effective bank equal, Addr_A==Addr_B, and at least one write. With PINGPONG=1 the banks always differ, so Collision stays 0.
- Ping-pong:
  - Port A accesses bank Bank; port B accesses bank ~Bank.
  - Swap=1 with En=1 toggles Bank on that edge; accesses on the same edge use the old mapping.
  - Swap with En=0 is ignored.
  - Back-to-back Swap cycles toggle Bank every cycle.
- Address wrap: addresses are AW bits with no range check; DEPTH is a power of two, so every address is valid.
- Writes and reads of different addresses on the two ports proceed concurrently with no stall.

Decomposition:
- Shared package rfft_mem_pkg:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1.
  - MODE_SHARED=0 and MODE_PINGPONG=1.
  - A clog2 function.
- Sub-module bram_bank: one DEPTH x WIDTH dual-port array with per-port read-first/write-first.
  - Instantiated once for PINGPONG=0, twice for PINGPONG=1.
- Top level holds the bank mux, Bank flop, collision detect and output/valid pipeline.

Test Plan:
- Reset: assert Rst mid-stream -> DO_A=DO_B=0, Vld=0, Bank=0, Collision=0 asynchronously. Data written before reset still reads back after it.
- Basic: WIDTH=32, DEPTH=64, OREG=0. Write 0xA5A5_0001 at A-addr 5, then read B-addr 5 -> DO_B=0xA5A5_0001 one cycle later with Vld_B=1. With OREG=1 -> two cycles later.
- RDW: addr 9 holds 0x11. Write 0x22 on port A to addr 9 while reading A -> DO_A=0x11 with RDW_MODE=0, DO_A=0x22 with RDW_MODE=1.
- Collision: same cycle, A writes 0x33 and B writes 0x44 at addr 12 -> Collision=1 for exactly one cycle, then readback of addr 12 = 0x33. A write plus B read at the same address -> B gets the old word and Collision pulses.
- Ping-pong: PINGPONG=1, Bank=0.
  - A writes 0..63 into bank 0, then Swap -> Bank=1.
  - B reads addr 0..63 -> values 0..63. Meanwhile A writes bank 1 at the same addresses with no Collision.
  - Swap with En=0 -> Bank unchanged.
- En gating: We_A=1 with En=0 at addr 3 -> memory unchanged, DO_A holds its previous value, Vld_A=0.
